// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator: sums a batch of SAMPLES 5-bit adder results {Overflow,Sum}
// into a saturating WIDTH-bit total, framed by a Start/Done/Ack handshake.
//   Clk      - clock, rising edge
//   Reset    - synchronous active-high reset, overrides all other inputs
//   Start    - begin a batch (IDLE only)
//   In_Valid - Sum/Overflow carry a new result (ACCUM only)
//   Sum      - adder sum bits
//   Overflow - adder carry-out
//   Ack      - consumer has read the result (DONE only)
//   Total    - saturating accumulated sum
//   Count    - results accepted in the current batch
//   Busy     - high in ACCUM
//   Done     - high in DONE
//   Sat      - sticky saturation flag for the current batch
module adder_sum_accumulator #(
    parameter int WIDTH   = 8,
    parameter int SAMPLES = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             In_Valid,
    input  logic [3:0]       Sum,
    input  logic             Overflow,
    input  logic             Ack,
    output logic [WIDTH-1:0] Total,
    output logic [3:0]       Count,
    output logic             Busy,
    output logic             Done,
    output logic             Sat
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] total_n;
    logic [3:0] count_n;
    logic sat_n;
    logic [WIDTH:0] addend, sum_ext;
    assign addend  = {{(WIDTH-4){1'b0}}, Overflow, Sum};
    // One extra bit: addend <= 31 so the sum can exceed the max by at most one carry.
    assign sum_ext = {1'b0, Total} + addend;
    assign Busy = (state == S_ACCUM);
    assign Done = (state == S_DONE);
    always_comb begin
        state_n = state;
        total_n = Total;
        count_n = Count;
        sat_n   = Sat;
        case (state)
            S_IDLE: if (Start) begin
                total_n = '0;
                count_n = '0;
                sat_n   = 1'b0;
                state_n = S_ACCUM;
            end
            S_ACCUM: if (In_Valid) begin
                total_n = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
                sat_n   = Sat | sum_ext[WIDTH];
                count_n = Count + 4'd1;
                state_n = (Count == 4'(SAMPLES - 1)) ? S_DONE : S_ACCUM;
            end
            S_DONE: if (Ack) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            Total <= '0;
            Count <= '0;
            Sat   <= 1'b0;
        end else begin
            state <= state_n;
            Total <= total_n;
            Count <= count_n;
            Sat   <= sat_n;
        end
    end
endmodule
